modexp_sequencer: RTL and testbench

- Controller that sequences one shared Montgomery multiplier through left-to-right square-and-multiply modular exponentiation.
- Sits between the serial byte loader and the multiplier.
- Takes the loader's one-cycle config strobe (exponent, top bit index, pass count) once x-bar and m-bar are in scratch RAM.
- Issues multiply commands by RAM address and reports completion; the result is left in the m-bar slot.

---
 rtl/modexp_sequencer_pkg.sv | 49 ++++
 rtl/modexp_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_modexp_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_sequencer_pkg
//  Description : Shared definitions for the modular-exponentiation sequencer:
//                default geometry, scratch RAM slot addresses, FSM state
//                encoding and the multiplier command field layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package modexp_sequencer_pkg;

    // Default geometry of the exponentiation datapath.
    localparam int MX_N     = 32;
    localparam int MX_NLOG2 = 5;
    localparam int MX_ABITS = 8;

    // Scratch RAM slots; these must match where the serial loader writes
    // x-bar (slot 0) and m-bar (slot 2). The result is left in the m-bar slot.
    localparam int MX_XBAR_ADDR = 0;
    localparam int MX_ACC_ADDR  = 2;

    // Sequencer states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SQ_ISSUE   = 3'd1,
        ST_SQ_WAIT    = 3'd2,
        ST_MUL_ISSUE  = 3'd3,
        ST_MUL_WAIT   = 3'd4,
        ST_CONV_ISSUE = 3'd5,
        ST_CONV_WAIT  = 3'd6,
        ST_FINISH     = 3'd7
    } state_t;

    // One multiplier command as seen on the mm_* bus (default geometry).
    // b_addr is meaningless when b_one is set (operand B is the constant 1).
    typedef struct packed {
        logic [MX_ABITS-1:0] a_addr;
        logic [MX_ABITS-1:0] b_addr;
        logic                b_one;
        logic [MX_ABITS-1:0] dst_addr;
        logic [MX_NLOG2-1:0] passes;
    } mm_cmd_t;

    // True for the single-cycle states that launch a multiplier command.
    function automatic logic is_issue_state(input state_t s);
        return (s == ST_SQ_ISSUE) || (s == ST_MUL_ISSUE) || (s == ST_CONV_ISSUE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/modexp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_sequencer
//  Description : Drives one shared Montgomery multiplier through
//                left-to-right square-and-multiply exponentiation, then a
//                final multiply-by-one to leave the Montgomery domain.
//                Operands live in scratch RAM; commands are issued by address.
//  Revision    : 1.0 - initial release
// ============================================================================
module modexp_sequencer
    import modexp_sequencer_pkg::*;
#(
    parameter int N         = MX_N,
    parameter int NLOG2     = MX_NLOG2,
    parameter int ABITS     = MX_ABITS,
    parameter int XBAR_ADDR = MX_XBAR_ADDR,
    parameter int ACC_ADDR  = MX_ACC_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [N-1:0]     cfg_e,
    input  logic [NLOG2-1:0] cfg_e_idx,
    input  logic [NLOG2-1:0] cfg_mp_count,
    output logic             mm_start,
    output logic [ABITS-1:0] mm_a_addr,
    output logic [ABITS-1:0] mm_b_addr,
    output logic             mm_b_one,
    output logic [ABITS-1:0] mm_dst_addr,
    output logic [NLOG2-1:0] mm_passes,
    input  logic             mm_done,
    output logic             busy,
    output logic             done,
    output logic             cfg_overrun
);

    localparam logic [ABITS-1:0] C_XBAR = ABITS'(XBAR_ADDR);
    localparam logic [ABITS-1:0] C_ACC  = ABITS'(ACC_ADDR);

    state_t             r_state;
    state_t             w_next_state;

    logic [N-1:0]       r_e;
    logic [NLOG2-1:0]   r_bit_idx;
    logic [NLOG2-1:0]   r_passes;

    logic               w_accept;
    logic               w_step_down;
    logic               w_cur_bit;
    logic               w_last_bit;
    logic [NLOG2-1:0]   w_passes_src;

    // Exponent bit under the pointer, and whether it is the final (LSB) one.
    assign w_cur_bit  = r_e[r_bit_idx];
    assign w_last_bit = (r_bit_idx == '0);

    // The first command issues in the same edge that latches the config, so
    // its pass count has to come straight from the config bus.
    assign w_passes_src = w_accept ? cfg_mp_count : r_passes;

    // State register; reset wins over everything, dropping any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, job acceptance and bit-pointer stepping.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step_down  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SQ_ISSUE;
                end
            end
            ST_SQ_ISSUE: begin
                w_next_state = ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
                if (mm_done) begin
                    if (w_cur_bit) begin
                        w_next_state = ST_MUL_ISSUE;
                    end else if (w_last_bit) begin
                        w_next_state = ST_CONV_ISSUE;
                    end else begin
                        w_step_down  = 1'b1;
                        w_next_state = ST_SQ_ISSUE;
                    end
                end
            end
            ST_MUL_ISSUE: begin
                w_next_state = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mm_done) begin
                    if (w_last_bit) begin
                        w_next_state = ST_CONV_ISSUE;
                    end else begin
                        w_step_down  = 1'b1;
                        w_next_state = ST_SQ_ISSUE;
                    end
                end
            end
            ST_CONV_ISSUE: begin
                w_next_state = ST_CONV_WAIT;
            end
            ST_CONV_WAIT: begin
                if (mm_done) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Job context: exponent, bit pointer and pass count, latched on accept.
    // The pointer only steps down while above zero, so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_e       <= '0;
            r_bit_idx <= '0;
            r_passes  <= '0;
        end else if (w_accept) begin
            r_e       <= cfg_e;
            r_bit_idx <= cfg_e_idx;
            r_passes  <= cfg_mp_count;
        end else if (w_step_down) begin
            r_bit_idx <= r_bit_idx - 1'b1;
        end
    end

    // Command bus: loaded on entry to an issue state and held until the next
    // one, so the multiplier sees stable fields for the whole operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mm_start    <= 1'b0;
            mm_a_addr   <= '0;
            mm_b_addr   <= '0;
            mm_b_one    <= 1'b0;
            mm_dst_addr <= '0;
            mm_passes   <= '0;
        end else begin
            mm_start <= is_issue_state(w_next_state);
            case (w_next_state)
                ST_SQ_ISSUE: begin
                    mm_a_addr   <= C_ACC;
                    mm_b_addr   <= C_ACC;
                    mm_b_one    <= 1'b0;
                    mm_dst_addr <= C_ACC;
                    mm_passes   <= w_passes_src;
                end
                ST_MUL_ISSUE: begin
                    mm_a_addr   <= C_ACC;
                    mm_b_addr   <= C_XBAR;
                    mm_b_one    <= 1'b0;
                    mm_dst_addr <= C_ACC;
                    mm_passes   <= w_passes_src;
                end
                ST_CONV_ISSUE: begin
                    mm_a_addr   <= C_ACC;
                    mm_b_addr   <= C_ACC;
                    mm_b_one    <= 1'b1;
                    mm_dst_addr <= C_ACC;
                    mm_passes   <= w_passes_src;
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags. busy drops in the same cycle done pulses; a config
    // strobe seen outside IDLE (FINISH included) is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_overrun <= 1'b0;
        end else begin
            busy <= (w_next_state != ST_IDLE) && (w_next_state != ST_FINISH);
            done <= (w_next_state == ST_FINISH);
            if (cfg_valid && (r_state != ST_IDLE)) begin
                cfg_overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modexp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modexp_sequencer
//  Description : Self-checking bench for modexp_sequencer. A multiplier model
//                answers each command 3 cycles later; a scoreboard of expected
//                commands is filled from the exponent when a job is launched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modexp_sequencer;
    import modexp_sequencer_pkg::*;

    localparam logic [7:0] XB = 8'd0;
    localparam logic [7:0] AC = 8'd2;

    typedef struct {
        logic [31:0] e;
        logic [4:0]  idx;
        logic [4:0]  mp;
        int          n_cmds;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_e = '0;
    logic [4:0]  cfg_e_idx = '0;
    logic [4:0]  cfg_mp_count = '0;
    logic        mm_start;
    logic [7:0]  mm_a_addr;
    logic [7:0]  mm_b_addr;
    logic        mm_b_one;
    logic [7:0]  mm_dst_addr;
    logic [4:0]  mm_passes;
    logic        mm_done;
    logic        busy;
    logic        done;
    logic        cfg_overrun;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;

    assign mm_done = model_done | spur_done;

    always #5 clk = ~clk;

    modexp_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_e        (cfg_e),
        .cfg_e_idx    (cfg_e_idx),
        .cfg_mp_count (cfg_mp_count),
        .mm_start     (mm_start),
        .mm_a_addr    (mm_a_addr),
        .mm_b_addr    (mm_b_addr),
        .mm_b_one     (mm_b_one),
        .mm_dst_addr  (mm_dst_addr),
        .mm_passes    (mm_passes),
        .mm_done      (mm_done),
        .busy         (busy),
        .done         (done),
        .cfg_overrun  (cfg_overrun)
    );

    int      n_pass = 0;
    int      n_total = 0;
    int      cyc = 0;
    int      n_starts = 0;
    int      n_done = 0;
    int      model_cnt = 0;
    int      exp_start_cyc = -1;
    int      exp_done_cyc = -1;
    int      last_start_cyc = -1;
    bit      aborted = 1'b0;
    mm_cmd_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mm_cmd_t mk(input logic [7:0] b, input logic bone, input logic [4:0] mp);
        mm_cmd_t c;
        c.a_addr   = AC;
        c.b_addr   = b;
        c.b_one    = bone;
        c.dst_addr = AC;
        c.passes   = mp;
        return c;
    endfunction

    // Expected command stream: per bit from idx down, square then multiply
    // when the bit is set; a single conversion closes the job.
    task automatic build_expected(input logic [31:0] e, input logic [4:0] idx, input logic [4:0] mp);
        for (int i = int'(idx); i >= 0; i--) begin
            sb.push_back(mk(AC, 1'b0, mp));
            if (e[i]) sb.push_back(mk(XB, 1'b0, mp));
        end
        sb.push_back(mk(AC, 1'b1, mp));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor and multiplier model, evaluated mid-cycle.
    always @(negedge clk) begin
        mm_cmd_t got;
        mm_cmd_t want;
        cyc++;
        model_done = 1'b0;
        if (cyc == exp_start_cyc) begin
            check("start_latency", 64'(mm_start), 64'd1);
            exp_start_cyc = -1;
        end else if (mm_start) begin
            check("unexpected_start", 64'(mm_start), 64'd0);
        end
        if (mm_start) begin
            n_starts++;
            last_start_cyc = cyc;
            check("busy_during_cmd", 64'(busy), 64'd1);
            if (sb.size() == 0) begin
                check("cmd_extra", 64'(sb.size()), 64'd1);
            end else begin
                want = sb.pop_front();
                got.a_addr   = mm_a_addr;
                got.b_addr   = want.b_one ? want.b_addr : mm_b_addr;
                got.b_one    = mm_b_one;
                got.dst_addr = mm_dst_addr;
                got.passes   = mm_passes;
                check("cmd", 64'(got), 64'(want));
            end
            model_cnt = 3;
        end else if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
                model_done = 1'b1;
                if (!aborted) begin
                    if (sb.size() == 0) exp_done_cyc = cyc + 1;
                    else exp_start_cyc = cyc + 1;
                end
            end
        end
        if (cyc == exp_done_cyc) begin
            check("done_latency", 64'(done), 64'd1);
            check("sb_drained", 64'(sb.size()), 64'd0);
            exp_done_cyc = -1;
        end else if (done) begin
            check("unexpected_done", 64'(done), 64'd0);
        end
        if (done) begin
            n_done++;
            check("busy_low_at_done", 64'(busy), 64'd0);
        end
    end

    // Launch a job and wait for its done pulse. Optionally poke a config
    // strobe or a stray mm_done poke_delay cycles after command #poke_after.
    task automatic run_job(input logic [31:0] e, input logic [4:0] idx, input logic [4:0] mp,
                           input int n_exp, input int poke_after, input bit poke_cfg,
                           input int poke_delay);
        int s0 = n_starts;
        int d0 = n_done;
        int t = 0;
        bit poked = 1'b0;
        build_expected(e, idx, mp);
        cfg_valid     = 1'b1;
        cfg_e         = e;
        cfg_e_idx     = idx;
        cfg_mp_count  = mp;
        exp_start_cyc = cyc + 1;
        step();
        cfg_valid = 1'b0;
        while (n_done == d0 && t < 3000) begin
            if (poke_after > 0 && !poked && (n_starts - s0) == poke_after &&
                cyc == last_start_cyc + poke_delay) begin
                poked = 1'b1;
                if (poke_cfg) begin
                    cfg_valid    = 1'b1;
                    cfg_e        = 32'h1;
                    cfg_e_idx    = 5'd0;
                    cfg_mp_count = 5'd9;
                end else begin
                    spur_done = 1'b1;
                end
            end
            step();
            t++;
            cfg_valid = 1'b0;
            spur_done = 1'b0;
        end
        check("job_done_seen", 64'(n_done - d0), 64'd1);
        check("job_cmd_count", 64'(n_starts - s0), 64'(n_exp));
        if (poke_after > 0) check("poke_applied", 64'(poked), 64'd1);
        step();
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t vecs[7];
        int   s0;
        int   d0;
        vecs[0] = '{e: 32'h0000000B, idx: 5'd3,  mp: 5'd5,  n_cmds: 8};
        vecs[1] = '{e: 32'h00000000, idx: 5'd0,  mp: 5'd1,  n_cmds: 2};
        vecs[2] = '{e: 32'h00000001, idx: 5'd0,  mp: 5'd2,  n_cmds: 3};
        vecs[3] = '{e: 32'hFFFFFFFF, idx: 5'd31, mp: 5'd31, n_cmds: 65};
        vecs[4] = '{e: 32'h000000F0, idx: 5'd3,  mp: 5'd7,  n_cmds: 5};
        vecs[5] = '{e: 32'h80000001, idx: 5'd31, mp: 5'd0,  n_cmds: 35};
        vecs[6] = '{e: 32'h0000005A, idx: 5'd6,  mp: 5'd3,  n_cmds: 12};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mm_start", 64'(mm_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overrun", 64'(cfg_overrun), 64'd0);
        check("rst_b_one", 64'(mm_b_one), 64'd0);
        check("rst_addrs", 64'({mm_a_addr, mm_b_addr, mm_dst_addr}), 64'd0);
        check("rst_passes", 64'(mm_passes), 64'd0);
        #1;
        rst = 1'b1;
        step();

        // Table-driven jobs, launched back to back (the cycle after FINISH)
        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].e, vecs[v].idx, vecs[v].mp, vecs[v].n_cmds, 0, 1'b0, 0);
        end
        check("no_overrun_yet", 64'(cfg_overrun), 64'd0);

        // Config strobe during MUL_WAIT is ignored and flagged
        run_job(32'hB, 5'd3, 5'd5, 8, 2, 1'b1, 1);
        check("overrun_set", 64'(cfg_overrun), 64'd1);
        repeat (3) step();
        check("overrun_sticky", 64'(cfg_overrun), 64'd1);

        // Stray mm_done in IDLE, then during an issue cycle
        s0 = n_starts;
        d0 = n_done;
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        repeat (5) step();
        check("idle_spur_starts", 64'(n_starts - s0), 64'd0);
        check("idle_spur_done", 64'(n_done - d0), 64'd0);
        check("idle_spur_busy", 64'(busy), 64'd0);
        run_job(32'h0, 5'd0, 5'd6, 2, 1, 1'b0, 0);

        // Reset during SQ_WAIT, late mm_done ignored, then a clean job
        build_expected(32'hB, 5'd3, 5'd5);
        cfg_valid     = 1'b1;
        cfg_e         = 32'hB;
        cfg_e_idx     = 5'd3;
        cfg_mp_count  = 5'd5;
        exp_start_cyc = cyc + 1;
        step();
        cfg_valid = 1'b0;
        step();
        rst           = 1'b0;
        aborted       = 1'b1;
        exp_start_cyc = -1;
        sb.delete();
        step();
        rst = 1'b1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_mm_start", 64'(mm_start), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_overrun", 64'(cfg_overrun), 64'd0);
        check("mid_rst_b_one", 64'(mm_b_one), 64'd0);
        check("mid_rst_addrs", 64'({mm_a_addr, mm_b_addr, mm_dst_addr}), 64'd0);
        check("mid_rst_passes", 64'(mm_passes), 64'd0);
        s0 = n_starts;
        d0 = n_done;
        repeat (6) step();
        check("late_done_starts", 64'(n_starts - s0), 64'd0);
        check("late_done_done", 64'(n_done - d0), 64'd0);
        aborted = 1'b0;
        run_job(32'h6, 5'd2, 5'd4, 6, 0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
